gnt_rr_arbiter: RTL and testbench

Round-robin grant arbiter that shares one downstream resource between N requesters wired to `my_if`-style lanes (ack as request, gnt as grant, irq as per-lane status byte). It sits between the interface array and the shared consumer. It issues at most one one-hot grant at a time and forwards the owner's irq byte downstream. An optional hold timeout forcibly reclaims a grant from a requester that never releases.

---
 rtl/gnt_rr_arbiter_if.sv | 25 ++
 rtl/gnt_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_gnt_rr_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gnt_rr_arbiter_if.sv
// Requester-lane bundle between the lane array (master) and the round-robin arbiter (slave).
interface gnt_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*8-1:0] irq_in;
    logic [N-1:0]   gnt;
    logic [OW-1:0]  owner;
    logic           busy;
    logic [7:0]     irq_out;
    logic           irq_valid;
    logic           timeout;

    modport master (
        output req, irq_in,
        input  gnt, owner, busy, irq_out, irq_valid, timeout
    );

    modport slave (
        input  req, irq_in,
        output gnt, owner, busy, irq_out, irq_valid, timeout
    );
endinterface

// File: rtl/gnt_rr_arbiter.sv
// Round-robin one-hot grant arbiter; gnt registered one edge after req, two gnt=0 cycles between grants.
// Level req is the only backpressure (no preemption); GNT_RR_ARBITER_TIMEOUT_EN adds a forced-release hold timeout.
module gnt_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gnt_rr_arbiter_if.slave  bus
);
    localparam int OW = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (N < 2 || N > 16 || HOLD_MAX < 2) begin : g_param_chk
        $error("gnt_rr_arbiter: N must be 2..16 and HOLD_MAX >= 2");
    end

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [7:0]    irq_q, irq_d;

    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          pick_vld;
    logic [7:0]    irq_sel;
    logic          hold_expired;

    // Search upward from last+1 so the previous owner is considered last.
    always_comb begin
        pick     = '0;
        idx      = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = OW'((int'(last_q) + i) % N);
            if (!pick_vld && bus.req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        irq_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                irq_sel = bus.irq_in[i*8 +: 8];
            end
        end
    end

`ifdef GNT_RR_ARBITER_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [CW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    // Counter is zero whenever GRANT is entered, so cycle k of a grant sees hold_q == k.
    always_comb begin
        hold_d       = (state_q == S_GRANT) ? hold_q + 1'b1 : '0;
        hold_expired = (hold_q == CW'(HOLD_MAX - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        irq_d   = irq_q;
`ifdef GNT_RR_ARBITER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    owner_d = pick;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                irq_d = irq_sel;
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (hold_expired) begin
                    gnt_d   = '0;
                    state_d = S_RELEASE;
`ifdef GNT_RR_ARBITER_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            S_RELEASE: begin
                gnt_d   = '0;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(N - 1);
            gnt_q   <= '0;
            irq_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.irq_out   = irq_q;
    assign bus.irq_valid = (state_q == S_GRANT) && (irq_q != 8'h00);
endmodule

// File: tb/tb_gnt_rr_arbiter.sv
// Directed vector table plus hand sequences for async reset and long-hold behaviour.
module tb_gnt_rr_arbiter;
    localparam logic [31:0] IRQ  = 32'h33_A5_11_10;
    localparam logic [31:0] IRQ0 = 32'h33_00_11_10;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] irq;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic [7:0]  irq_out;
        logic        vchk;
        logic        irq_valid;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;
    vec_t tbl[$];

    gnt_rr_arbiter_if #(.N(4)) bus ();

    gnt_rr_arbiter #(.N(4), .HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] ir,
                       input logic [3:0] g, input logic [1:0] o, input logic b,
                       input logic [7:0] io, input logic vc, input logic iv);
        vec_t v;
        v.rst_n = r;  v.req = rq; v.irq = ir; v.gnt = g; v.owner = o; v.busy = b;
        v.irq_out = io; v.vchk = vc; v.irq_valid = iv;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input bit ok, input string detail);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        rst_n      = 1'b0;
        bus.req    = 4'b1111;
        bus.irq_in = IRQ;

        //   rst req     irq   gnt     own b  irq_out vchk val
        add(0, 4'b1111, IRQ,  4'b0000, 0, 0, 8'h00, 1, 0);
        add(1, 4'b1111, IRQ,  4'b0001, 0, 1, 8'h00, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0001, 0, 1, 8'h10, 1, 1);
        add(1, 4'b1011, IRQ,  4'b0001, 0, 1, 8'h10, 1, 1);
        add(1, 4'b1010, IRQ,  4'b0000, 0, 1, 8'h10, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0000, 0, 0, 8'h10, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0010, 1, 1, 8'h10, 0, 0);
        add(1, 4'b1011, IRQ,  4'b0010, 1, 1, 8'h11, 1, 1);
        add(1, 4'b1011, IRQ,  4'b0010, 1, 1, 8'h11, 1, 1);
        add(1, 4'b1001, IRQ,  4'b0000, 1, 1, 8'h11, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0000, 1, 0, 8'h11, 1, 0);
        add(1, 4'b1011, IRQ,  4'b1000, 3, 1, 8'h11, 0, 0);
        add(1, 4'b1011, IRQ,  4'b1000, 3, 1, 8'h33, 1, 1);
        add(1, 4'b1011, IRQ,  4'b1000, 3, 1, 8'h33, 1, 1);
        add(1, 4'b0011, IRQ,  4'b0000, 3, 1, 8'h33, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0000, 3, 0, 8'h33, 1, 0);
        add(1, 4'b1011, IRQ,  4'b0001, 0, 1, 8'h33, 0, 0);
        add(1, 4'b0000, IRQ,  4'b0000, 0, 1, 8'h10, 1, 0);
        add(1, 4'b0000, IRQ,  4'b0000, 0, 0, 8'h10, 1, 0);
        add(1, 4'b0100, IRQ,  4'b0100, 2, 1, 8'h10, 0, 0);
        add(1, 4'b0100, IRQ,  4'b0100, 2, 1, 8'hA5, 1, 1);
        add(1, 4'b0100, IRQ0, 4'b0100, 2, 1, 8'h00, 1, 0);
        add(1, 4'b0100, IRQ,  4'b0100, 2, 1, 8'hA5, 1, 1);
        add(1, 4'b0000, IRQ,  4'b0000, 2, 1, 8'hA5, 1, 0);
        add(1, 4'b0000, IRQ,  4'b0000, 2, 0, 8'hA5, 1, 0);
        add(1, 4'b1000, IRQ,  4'b1000, 3, 1, 8'hA5, 0, 0);
        add(1, 4'b1001, IRQ,  4'b1000, 3, 1, 8'h33, 1, 1);
        add(1, 4'b1001, IRQ,  4'b1000, 3, 1, 8'h33, 1, 1);
        add(1, 4'b0001, IRQ,  4'b0000, 3, 1, 8'h33, 1, 0);
        add(1, 4'b0001, IRQ,  4'b0000, 3, 0, 8'h33, 1, 0);
        add(1, 4'b0001, IRQ,  4'b0001, 0, 1, 8'h33, 0, 0);
        add(1, 4'b0000, IRQ,  4'b0000, 0, 1, 8'h10, 1, 0);
        add(1, 4'b0000, IRQ,  4'b0000, 0, 0, 8'h10, 1, 0);

        // Reset asserted before any clock edge: every output already at its reset value.
        #3;
        check("reset_pre_edge",
              bus.gnt == 4'b0000 && bus.owner == 2'd0 && !bus.busy && bus.irq_out == 8'h00 &&
              !bus.irq_valid && !bus.timeout,
              $sformatf("got gnt=%b owner=%0d busy=%b irq_out=%h irq_valid=%b timeout=%b, want all 0",
                        bus.gnt, bus.owner, bus.busy, bus.irq_out, bus.irq_valid, bus.timeout));

        foreach (tbl[k]) begin
            rst_n      = tbl[k].rst_n;
            bus.req    = tbl[k].req;
            bus.irq_in = tbl[k].irq;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", k),
                  bus.gnt == tbl[k].gnt && bus.owner == tbl[k].owner && bus.busy == tbl[k].busy &&
                  bus.irq_out == tbl[k].irq_out && !bus.timeout &&
                  (!tbl[k].vchk || bus.irq_valid == tbl[k].irq_valid),
                  $sformatf("got gnt=%b owner=%0d busy=%b irq_out=%h irq_valid=%b timeout=%b; want gnt=%b owner=%0d busy=%b irq_out=%h irq_valid=%b timeout=0",
                            bus.gnt, bus.owner, bus.busy, bus.irq_out, bus.irq_valid, bus.timeout,
                            tbl[k].gnt, tbl[k].owner, tbl[k].busy, tbl[k].irq_out, tbl[k].irq_valid));
        end

        // Async reset between edges while lane 2 owns the grant (last owner was lane 0).
        bus.req = 4'b0100;
        @(posedge clk);
        #1;
        check("async_pre_grant", bus.gnt == 4'b0100,
              $sformatf("got gnt=%b, want 0100", bus.gnt));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_drop",
              bus.gnt == 4'b0000 && bus.owner == 2'd0 && !bus.busy && bus.irq_out == 8'h00 && !bus.irq_valid,
              $sformatf("got gnt=%b owner=%0d busy=%b irq_out=%h irq_valid=%b, want all 0",
                        bus.gnt, bus.owner, bus.busy, bus.irq_out, bus.irq_valid));
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0101;
        @(posedge clk);
        #1;
        check("post_reset_priority", bus.gnt == 4'b0001 && bus.owner == 2'd0,
              $sformatf("got gnt=%b owner=%0d, want gnt=0001 owner=0", bus.gnt, bus.owner));

        @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Lane 1 holds its request forever with lane 2 waiting (last owner lane 0).
        bus.req = 4'b0110;
`ifdef GNT_RR_ARBITER_TIMEOUT_EN
        begin
            int         hi;
            int         tos;
            bit         rel;
            bit         to_at_rel;
            logic [3:0] nxt;
            hi = 0; tos = 0; rel = 0; to_at_rel = 0; nxt = '0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.timeout && nxt == 4'b0000) tos++;
                if (!rel) begin
                    if (bus.gnt == 4'b0010) hi++;
                    else if (hi > 0) begin
                        rel       = 1;
                        to_at_rel = bus.timeout;
                    end
                end else if (nxt == 4'b0000 && bus.gnt != 4'b0000) begin
                    nxt = bus.gnt;
                end
            end
            check("timeout_hold", hi == 8 && tos == 1 && to_at_rel && nxt == 4'b0100,
                  $sformatf("got hold=%0d pulses=%0d pulse_at_release=%b next_gnt=%b; want hold=8 pulses=1 pulse_at_release=1 next_gnt=0100",
                            hi, tos, to_at_rel, nxt));
        end
`else
        begin
            int hi;
            int tos;
            hi = 0; tos = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.gnt == 4'b0010) hi++;
                if (bus.timeout) tos++;
            end
            check("hold_no_timeout", hi == 100 && tos == 0,
                  $sformatf("got gnt[1] cycles=%0d timeout pulses=%0d; want 100 and 0", hi, tos));
        end
`endif
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
